gpio_sequencer: RTL

Programmable write sequencer and bus arbiter in front of the nano-Z80 GPIO core's register port. The CPU programs a short table of GPIO register writes (target register and data) and a dwell time. The block replays the table with cycle-accurate spacing, once or looping. The CPU keeps direct GPIO access through a pass-through port that always wins arbitration.

---
 rtl/gpio_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/gpio_sequencer.sv
// Write sequencer and arbiter in front of the GPIO core register port.
// Replays a small table of {register, data} writes with a programmable dwell; CPU pass-through always wins.
module gpio_sequencer #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned DWELL_W = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       cpu_seq_cs,
  input  logic       cpu_gpio_cs,
  input  logic       cpu_wr_n,
  input  logic [2:0] cpu_addr,
  input  logic [7:0] cpu_data_i,
  output logic [7:0] cpu_data_o,
  output logic       gpio_cs,
  output logic       gpio_wr_n,
  output logic [1:0] gpio_reg_addr,
  output logic [7:0] gpio_data_o,
  input  logic [7:0] gpio_data_i
);

  localparam int unsigned STEP_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DWELL = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0]   ptr_q, ptr_d;
  logic [1:0]          staged_q, staged_d;
  logic                run_q, run_d;
  logic                loop_q, loop_d;
  logic [2:0]          last_q, last_d;
  logic [7:0]          dwell_lo_q, dwell_lo_d;
  logic [7:0]          dwell_hi_q, dwell_hi_d;
  logic                done_q, done_d;
  logic [1:0]          tbl_addr_q [DEPTH];
  logic [1:0]          tbl_addr_d [DEPTH];
  logic [7:0]          tbl_data_q [DEPTH];
  logic [7:0]          tbl_data_d [DEPTH];

  logic                seq_wr;
  logic                ctrl_wr;
  logic                busy;
  logic [STEP_W-1:0]   last_eff;
  logic [DWELL_W-1:0]  dwell_val;
  logic [15:0]         dwell_rd;

  assign seq_wr    = cpu_seq_cs && !cpu_gpio_cs && !cpu_wr_n;
  assign ctrl_wr   = seq_wr && (cpu_addr == 3'd0);
  assign busy      = (state_q != S_IDLE);
  assign last_eff  = last_q[STEP_W-1:0];
  assign dwell_val = DWELL_W'({dwell_hi_q, dwell_lo_q});
  assign dwell_rd  = 16'(dwell_val);

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    staged_d   = staged_q;
    run_d      = run_q;
    loop_d     = loop_q;
    last_d     = last_q;
    dwell_lo_d = dwell_lo_q;
    dwell_hi_d = dwell_hi_q;
    done_d     = done_q;
    tbl_addr_d = tbl_addr_q;
    tbl_data_d = tbl_data_q;

    if (seq_wr) begin
      case (cpu_addr)
        3'd0: begin
          run_d  = cpu_data_i[0];
          loop_d = cpu_data_i[1];
          last_d = cpu_data_i[6:4];
          if (cpu_data_i[0] && !run_q) done_d = 1'b0;
        end
        3'd1: ptr_d    = cpu_data_i[STEP_W-1:0];
        3'd2: staged_d = cpu_data_i[1:0];
        3'd3: begin
          tbl_addr_d[ptr_q] = staged_q;
          tbl_data_d[ptr_q] = cpu_data_i;
          ptr_d             = ptr_q + 1'b1;
        end
        3'd4: dwell_lo_d = cpu_data_i;
        3'd5: dwell_hi_d = cpu_data_i;
        3'd6: done_d     = 1'b0;
        default: ;
      endcase
    end

    // IDLE looks at run_d so a run written this edge starts ISSUE on the same edge.
    case (state_q)
      S_IDLE: begin
        if (run_d) begin
          state_d = S_ISSUE;
          step_d  = '0;
        end
      end
      S_ISSUE: begin
        if (!cpu_gpio_cs) begin
          state_d = S_DWELL;
          cnt_d   = dwell_val;
        end
      end
      S_DWELL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (step_q != last_eff) begin
          step_d  = step_q + 1'b1;
          state_d = S_ISSUE;
        end else if (loop_q) begin
          step_d  = '0;
          state_d = S_ISSUE;
        end else begin
          done_d  = 1'b1;
          run_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A CTRL write overrides the FSM's own run update; run=0 aborts to IDLE, step held.
    if (ctrl_wr) begin
      run_d = cpu_data_i[0];
      if (!cpu_data_i[0]) state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      staged_q   <= '0;
      run_q      <= 1'b0;
      loop_q     <= 1'b0;
      last_q     <= '0;
      dwell_lo_q <= '0;
      dwell_hi_q <= '0;
      done_q     <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl_addr_q[i] <= '0;
        tbl_data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      staged_q   <= staged_d;
      run_q      <= run_d;
      loop_q     <= loop_d;
      last_q     <= last_d;
      dwell_lo_q <= dwell_lo_d;
      dwell_hi_q <= dwell_hi_d;
      done_q     <= done_d;
      tbl_addr_q <= tbl_addr_d;
      tbl_data_q <= tbl_data_d;
    end
  end

  always_comb begin
    gpio_cs       = 1'b0;
    gpio_wr_n     = 1'b1;
    gpio_reg_addr = '0;
    gpio_data_o   = '0;
    if (cpu_gpio_cs) begin
      gpio_cs       = 1'b1;
      gpio_wr_n     = cpu_wr_n;
      gpio_reg_addr = cpu_addr[1:0];
      gpio_data_o   = cpu_data_i;
    end else if (state_q == S_ISSUE) begin
      gpio_cs       = 1'b1;
      gpio_wr_n     = 1'b0;
      gpio_reg_addr = tbl_addr_q[step_q];
      gpio_data_o   = tbl_data_q[step_q];
    end
  end

  always_comb begin
    cpu_data_o = '0;
    if (cpu_gpio_cs) begin
      cpu_data_o = gpio_data_i;
    end else if (cpu_seq_cs) begin
      case (cpu_addr)
        3'd0:    cpu_data_o = {busy, last_q, 2'b00, loop_q, run_q};
        3'd1:    cpu_data_o = 8'(ptr_q);
        3'd2:    cpu_data_o = {6'b0, staged_q};
        3'd4:    cpu_data_o = dwell_rd[7:0];
        3'd5:    cpu_data_o = dwell_rd[15:8];
        3'd6:    cpu_data_o = {done_q, 4'b0, 3'(step_q)};
        default: cpu_data_o = '0;
      endcase
    end
  end

endmodule
